// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam logic [3:0] REG_R15  = 4'd15;

    // r0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [3:0] src,
                                       input logic [3:0] rd,
                                       input logic       wb);
        return (src == rd) && wb && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: stage tags in, enables/flushes/forward selects out.
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_use_r15;
    logic       ex_valid;
    logic [3:0] ex_rd;
    logic       ex_wb;
    logic       ex_load;
    logic       ex_mdu;
    logic       ex_br_taken;
    logic [3:0] mem_rd;
    logic       mem_wb;
    logic [3:0] wb_rd;
    logic       wb_wb;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_m_en;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       r15_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_r15,
        output ex_valid, ex_rd, ex_wb, ex_load, ex_mdu, ex_br_taken,
        output mem_rd, mem_wb, wb_rd, wb_wb,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_m_en,
        input  fwd_a, fwd_b, r15_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_r15,
        input  ex_valid, ex_rd, ex_wb, ex_load, ex_mdu, ex_br_taken,
        input  mem_rd, mem_wb, wb_rd, wb_wb,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_m_en,
        output fwd_a, fwd_b, r15_busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Loadable down-counter timing the MDU occupancy of EX.
// zero_o flags that the current decrement is the last one (count is 1 or already 0).
module mdu_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward sequencer for the 4-register pipeline; define PIPE_FWD_EN to enable operand
// forwarding, otherwise RAW dependencies are resolved purely by stalling.
//
//   state    | meaning
//   IDLE     | pipe flowing; branch, load-use/RAW and R15 hazards evaluated
//   MDU_BUSY | mul/div occupying EX; whole pipe frozen, timer counting down
//   MDU_DONE | last MDU cycle; EX/M captures the result, pipe released
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MDU_CYCLES = 4,
    parameter int CNT_W      = $clog2(MDU_CYCLES)
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    state_e state_q;
    state_e state_d;
    logic   r15_busy_q, r15_busy_d;
    logic   r15_pend_q, r15_pend_d;

    logic use_rs, use_rt;
    logic raw_stall, r15_stall, mdu_issue, tmr_zero;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_m_en;

    assign use_rs = hz.id_valid & hz.id_use_rs;
    assign use_rt = hz.id_valid & hz.id_use_rt;

`ifdef PIPE_FWD_EN
    // Only a load in EX cannot be covered by forwarding next cycle.
    assign raw_stall = hz.ex_valid & hz.ex_load &
                       ((use_rs & reg_match(hz.id_rs, hz.ex_rd, hz.ex_wb)) |
                        (use_rt & reg_match(hz.id_rt, hz.ex_rd, hz.ex_wb)));

    assign hz.fwd_a = (use_rs & reg_match(hz.id_rs, hz.mem_rd, hz.mem_wb)) ? FWD_MEM :
                      (use_rs & reg_match(hz.id_rs, hz.wb_rd,  hz.wb_wb))  ? FWD_WB  : FWD_RF;
    assign hz.fwd_b = (use_rt & reg_match(hz.id_rt, hz.mem_rd, hz.mem_wb)) ? FWD_MEM :
                      (use_rt & reg_match(hz.id_rt, hz.wb_rd,  hz.wb_wb))  ? FWD_WB  : FWD_RF;
`else
    // M/WB writes through the register file in its own cycle, so only EX and EX/M producers stall.
    assign raw_stall =
        (use_rs & ((hz.ex_valid & reg_match(hz.id_rs, hz.ex_rd, hz.ex_wb)) |
                   reg_match(hz.id_rs, hz.mem_rd, hz.mem_wb))) |
        (use_rt & ((hz.ex_valid & reg_match(hz.id_rt, hz.ex_rd, hz.ex_wb)) |
                   reg_match(hz.id_rt, hz.mem_rd, hz.mem_wb)));

    assign hz.fwd_a = FWD_RF;
    assign hz.fwd_b = FWD_RF;

    logic unused_in;
    assign unused_in = ^{hz.ex_load, hz.wb_rd, hz.wb_wb};
`endif

    assign r15_stall = hz.id_valid & hz.id_use_r15 & r15_busy_q;
    assign mdu_issue = (state_q == IDLE) & hz.ex_valid & hz.ex_mdu;

    mdu_timer #(.CNT_W(CNT_W)) u_mdu_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (mdu_issue),
        .load_val_i (CNT_W'(MDU_CYCLES - 2)),
        .dec_i      (state_q == MDU_BUSY),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_m_en     = 1'b1;
        case (state_q)
            IDLE: begin
                if (mdu_issue) begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    ex_m_en  = 1'b0;
                    state_d  = (MDU_CYCLES == 2) ? MDU_DONE : MDU_BUSY;
                end else if (hz.ex_br_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (raw_stall || r15_stall) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MDU_BUSY: begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
                id_ex_en = 1'b0;
                ex_m_en  = 1'b0;
                if (tmr_zero) begin
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // R15 stays busy through the EX/M cycle after MDU_DONE and reads clean once it reaches M/WB.
    always_comb begin
        r15_busy_d = r15_busy_q;
        r15_pend_d = r15_pend_q;
        if (mdu_issue) begin
            r15_busy_d = 1'b1;
            r15_pend_d = 1'b0;
        end else if (r15_pend_q) begin
            r15_busy_d = 1'b0;
            r15_pend_d = 1'b0;
        end else if (state_q == MDU_DONE) begin
            r15_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            r15_busy_q <= 1'b0;
            r15_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r15_busy_q <= r15_busy_d;
            r15_pend_q <= r15_pend_d;
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.id_ex_flush = id_ex_flush;
    assign hz.ex_m_en     = ex_m_en;
    assign hz.r15_busy    = r15_busy_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios followed by random stage traffic.
module tb_pipe_hazard_ctrl;

    localparam int MDU_CYCLES = 4;

    typedef struct packed {
        logic       v;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urs;
        logic       urt;
        logic       ur15;
        logic       ev;
        logic [3:0] erd;
        logic       ewb;
        logic       eld;
        logic       emdu;
        logic       ebr;
        logic [3:0] mrd;
        logic       mwb;
        logic [3:0] wrd;
        logic       wwb;
    } stim_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // expected = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_m_en, fwd_a, fwd_b, r15_busy}
    logic [10:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cyc = -1000;

    function automatic logic hit(input logic [3:0] s, input logic [3:0] rd, input logic wb);
        return (s == rd) && wb && (rd != 4'd0);
    endfunction

    // Reference model: timeline by absolute cycle numbers relative to the last MDU issue.
    task automatic step(input stim_t s, input logic r);
        int done_c;
        logic busy, idle, stall, ua, ub;
        logic [1:0] fa, fb;
        logic [5:0] ctl;
        @(posedge clk);
        #1;
        rst            = r;
        hz.id_valid    = s.v;
        hz.id_rs       = s.rs;
        hz.id_rt       = s.rt;
        hz.id_use_rs   = s.urs;
        hz.id_use_rt   = s.urt;
        hz.id_use_r15  = s.ur15;
        hz.ex_valid    = s.ev;
        hz.ex_rd       = s.erd;
        hz.ex_wb       = s.ewb;
        hz.ex_load     = s.eld;
        hz.ex_mdu      = s.emdu;
        hz.ex_br_taken = s.ebr;
        hz.mem_rd      = s.mrd;
        hz.mem_wb      = s.mwb;
        hz.wb_rd       = s.wrd;
        hz.wb_wb       = s.wwb;
        cyc++;
        if (!r) issue_cyc = -1000;
        done_c = issue_cyc + MDU_CYCLES - 1;
        busy   = (cyc > issue_cyc) && (cyc <= done_c + 1);
        idle   = (cyc > done_c);
        ua = s.v & s.urs;
        ub = s.v & s.urt;
        fa = 2'b00;
        fb = 2'b00;
`ifdef PIPE_FWD_EN
        if (ua && hit(s.rs, s.mrd, s.mwb))      fa = 2'b01;
        else if (ua && hit(s.rs, s.wrd, s.wwb)) fa = 2'b10;
        if (ub && hit(s.rt, s.mrd, s.mwb))      fb = 2'b01;
        else if (ub && hit(s.rt, s.wrd, s.wwb)) fb = 2'b10;
        stall = s.ev && s.eld && ((ua && hit(s.rs, s.erd, s.ewb)) || (ub && hit(s.rt, s.erd, s.ewb)));
`else
        stall = (ua && ((s.ev && hit(s.rs, s.erd, s.ewb)) || hit(s.rs, s.mrd, s.mwb))) ||
                (ub && ((s.ev && hit(s.rt, s.erd, s.ewb)) || hit(s.rt, s.mrd, s.mwb)));
`endif
        stall = stall || (s.v && s.ur15 && busy);
        ctl = 6'b110101;
        if (!idle) begin
            if (cyc != done_c) ctl = 6'b000000;
        end else if (s.ev && s.emdu) begin
            issue_cyc = cyc;
            ctl = 6'b000000;
        end else if (s.ebr) begin
            ctl = 6'b111111;
        end else if (stall) begin
            ctl = 6'b000111;
        end
        exp_q.push_back({ctl, fa, fb, busy});
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        logic [10:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush, hz.ex_m_en,
                 hz.fwd_a, hz.fwd_b, hz.r15_busy};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctrl_outputs cycle=%0d got=%b expected=%b (pc,ifen,iffl,iden,idfl,exen,fa,fb,r15)",
                         cyc, a, e);
            end
        end
    end

    function automatic logic [3:0] rreg();
        int k;
        k = $urandom_range(0, 3);
        return (k == 0) ? 4'd0 : (k == 1) ? 4'd3 : (k == 2) ? 4'd5 : 4'd15;
    endfunction

    initial begin
        stim_t s;
        stim_t z;
        z = '0;
        step(z, 1'b0);
        step(z, 1'b0);
        step(z, 1'b1);

        // forwarding from EX/M, then same with r0
        s = z; s.v = 1; s.urs = 1; s.rs = 4'd3; s.mrd = 4'd3; s.mwb = 1;
        step(s, 1'b1);
        s.rs = 4'd0; s.mrd = 4'd0;
        step(s, 1'b1);

        // load-use on rt, then load moved to EX/M
        s = z; s.v = 1; s.urt = 1; s.rt = 4'd5; s.ev = 1; s.eld = 1; s.erd = 4'd5; s.ewb = 1;
        step(s, 1'b1);
        s.ev = 0; s.eld = 0; s.erd = 4'd0; s.ewb = 0; s.mrd = 4'd5; s.mwb = 1;
        step(s, 1'b1);

        // ALU producer walking EX -> EX/M -> M/WB under a dependent consumer
        s = z; s.v = 1; s.urs = 1; s.rs = 4'd3; s.ev = 1; s.erd = 4'd3; s.ewb = 1;
        step(s, 1'b1);
        s.ev = 0; s.erd = 4'd0; s.ewb = 0; s.mrd = 4'd3; s.mwb = 1;
        step(s, 1'b1);
        s.mrd = 4'd0; s.mwb = 0; s.wrd = 4'd3; s.wwb = 1;
        step(s, 1'b1);

        // taken branch wins over load-use
        s = z; s.v = 1; s.urs = 1; s.rs = 4'd5; s.ev = 1; s.eld = 1; s.erd = 4'd5; s.ewb = 1; s.ebr = 1;
        step(s, 1'b1);

        // MUL then mfhi waiting on R15
        s = z; s.ev = 1; s.emdu = 1; s.erd = 4'd3; s.ewb = 1;
        step(s, 1'b1);
        s = z; s.v = 1; s.ur15 = 1;
        for (int i = 0; i < 7; i++) step(s, 1'b1);

        // reset while the MDU timer sits at 1
        s = z; s.ev = 1; s.emdu = 1;
        step(s, 1'b1);
        step(z, 1'b1);
        step(z, 1'b0);
        s = z; s.v = 1; s.ur15 = 1;
        step(s, 1'b1);
        step(s, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            s.v    = ($urandom_range(0, 9) != 0);
            s.rs   = rreg();
            s.rt   = rreg();
            s.urs  = $urandom_range(0, 1);
            s.urt  = $urandom_range(0, 1);
            s.ur15 = ($urandom_range(0, 3) == 0);
            s.ev   = ($urandom_range(0, 4) != 0);
            s.erd  = rreg();
            s.ewb  = $urandom_range(0, 1);
            s.eld  = ($urandom_range(0, 2) == 0);
            s.emdu = ($urandom_range(0, 9) == 0);
            s.ebr  = ($urandom_range(0, 7) == 0);
            s.mrd  = rreg();
            s.mwb  = $urandom_range(0, 1);
            s.wrd  = rreg();
            s.wwb  = $urandom_range(0, 1);
            if ($urandom_range(0, 149) == 0) step(z, 1'b0);
            else                             step(s, 1'b1);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
